// File: rtl/dbg_burst_wr_target_if.sv
// dbg_burst_wr_target_if: command, data, memory and response bus of the burst write target
//   cmd_*   : burst command from the debug-unit decoder (valid/ready)
//   wdata_* : data words, then the trailing CRC word (valid/ready)
//   mem_*   : word write port toward the memory fabric (req/gnt)
//   rsp_*   : status response (valid/ready), busy flag
interface dbg_burst_wr_target_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_nwords;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [31:0]           wdata;
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [7:0]            rsp_count;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_nwords, wdata_valid, wdata, mem_gnt, rsp_ready,
        output cmd_ready, wdata_ready, mem_req, mem_addr, mem_wdata, mem_we, mem_be,
               rsp_valid, rsp_err, rsp_count, busy
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_nwords, wdata_valid, wdata, mem_gnt, rsp_ready,
        input  cmd_ready, wdata_ready, mem_req, mem_addr, mem_wdata, mem_we, mem_be,
               rsp_valid, rsp_err, rsp_count, busy
    );
endinterface

// File: rtl/dbg_burst_wr_target.sv
// dbg_burst_wr_target: debug burst write responder; writes words to memory, checks trailing CRC-32
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of dbg_burst_wr_target_if (command, data, memory, response, busy)
module dbg_burst_wr_target #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WORDS  = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    dbg_burst_wr_target_if.slave bus
);
    localparam int RW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, DATA, MEMWR, CRC, RESP} state_t;

    state_t        state;
    logic [RW-1:0] remaining;
    logic [31:0]   crc;

    // Reflected CRC-32 over one full word, bit 0 first, no final XOR.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    assign bus.mem_we = bus.mem_req;
    assign bus.mem_be = 4'hF;

    // Every handshake output is a register updated together with the state,
    // so nothing combinational reaches the outputs from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            remaining       <= '0;
            crc             <= '0;
            bus.cmd_ready   <= 1'b1;
            bus.wdata_ready <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_count   <= '0;
            bus.busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    bus.cmd_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    bus.rsp_count <= '0;
                    if (bus.cmd_nwords != 8'd0) begin
                        state           <= DATA;
                        bus.mem_addr    <= bus.cmd_addr & ~ADDR_WIDTH'(3);
                        remaining       <= bus.cmd_nwords;
                        crc             <= 32'hFFFF_FFFF;
                        bus.wdata_ready <= 1'b1;
                    end else begin
                        state         <= RESP;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                DATA: if (bus.wdata_valid) begin
                    state           <= MEMWR;
                    bus.wdata_ready <= 1'b0;
                    bus.mem_wdata   <= bus.wdata;
                    crc             <= crc_word(crc, bus.wdata);
                    bus.mem_req     <= 1'b1;
                end
                MEMWR: if (bus.mem_gnt) begin
                    state           <= (remaining == RW'(1)) ? CRC : DATA;
                    bus.mem_req     <= 1'b0;
                    bus.mem_addr    <= bus.mem_addr + ADDR_WIDTH'(4);
                    bus.rsp_count   <= bus.rsp_count + 8'd1;
                    remaining       <= remaining - RW'(1);
                    bus.wdata_ready <= 1'b1;
                end
                CRC: if (bus.wdata_valid) begin
                    state           <= RESP;
                    bus.wdata_ready <= 1'b0;
                    bus.rsp_err     <= (bus.wdata != crc);
                    bus.rsp_valid   <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_burst_wr_target.sv
// tb_dbg_burst_wr_target: vector table, random backpressure bursts and mid-burst reset against a CRC/memory model
module tb_dbg_burst_wr_target;
    typedef struct {
        logic [31:0] addr;
        int          n;
        int          pat;
        bit          bad;
        bit          exp_err;
        int          exp_cnt;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          gap;
        int          gmax;
        int          hold;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          errors;
    int          checks;
    int          wcons;
    logic [63:0] writes[$];
    logic [31:0] bdata[$];
    logic [31:0] crc_tab[256];
    vec_t        tbl[7];
    vec_t        v;

    dbg_burst_wr_target_if #(.ADDR_WIDTH(32)) bus();

    dbg_burst_wr_target #(.ADDR_WIDTH(32), .MAX_WORDS(255)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe what will be sampled at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_req && bus.mem_gnt) writes.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.wdata_valid && bus.wdata_ready) wcons++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Byte-table CRC-32 (reflected, LSB-first bytes, init all ones, no final XOR).
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        foreach (bdata[i])
            for (int k = 0; k < 4; k++) begin
                b = bdata[i][8*k +: 8];
                c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
            end
        return c;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        chk({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'hF);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_rsp_count"}, 32'(bus.rsp_count), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic run_burst(input vec_t b);
        logic [31:0] c;
        logic [31:0] base;
        logic [31:0] pa;
        logic [31:0] pd;
        int          idx;
        int          gw;
        int          gt;
        int          lat;
        bit          crc_done;
        bit          pstall;
        bit          hs;
        bdata.delete();
        for (int i = 0; i < b.n; i++)
            bdata.push_back(b.pat == 1 ? 32'(i) : b.pat == 2 ? 32'h80 : $urandom);
        c = model_crc() ^ (b.bad ? 32'h1 : 32'h0);
        base = b.addr & ~32'h3;
        writes.delete();
        wcons = 0;
        for (int t = 0; t < 20 && !bus.cmd_ready; t++) tick();
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.wdata_valid = (b.n == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = b.addr;
        bus.cmd_nwords = 8'(b.n);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = $urandom;
        bus.cmd_nwords = 8'($urandom);
        chk("busy_after_cmd", 32'(bus.busy), 1);
        chk("cmd_ready_after_cmd", 32'(bus.cmd_ready), 0);
        if (b.n == 0) chk("zero_rsp_next", 32'(bus.rsp_valid), 1);
        else chk("wdata_ready_next", 32'(bus.wdata_ready), 1);
        idx = 0;
        crc_done = (b.n == 0);
        gw = 0;
        gt = $urandom_range(0, b.gmax);
        pstall = 1'b0;
        pa = '0;
        pd = '0;
        lat = 1;
        for (int t = 0; t < 40 * b.n + 40 && !bus.rsp_valid; t++) begin
            if (pstall && bus.mem_req) begin
                chk("mem_addr_stable", bus.mem_addr, pa);
                chk("mem_wdata_stable", bus.mem_wdata, pd);
            end
            bus.wdata_valid = !crc_done && ($urandom_range(0, 99) >= b.gap);
            bus.wdata = idx < b.n ? bdata[idx] : c;
            bus.mem_gnt = bus.mem_req && (gw >= gt);
            pstall = bus.mem_req && !bus.mem_gnt;
            pa = bus.mem_addr;
            pd = bus.mem_wdata;
            hs = bus.wdata_valid && bus.wdata_ready;
            tick();
            lat++;
            if (hs) begin
                if (idx < b.n) idx++;
                else crc_done = 1'b1;
            end
            if (bus.mem_gnt) begin
                gw = 0;
                gt = $urandom_range(0, b.gmax);
            end else if (pstall) gw++;
        end
        bus.mem_gnt = 1'b0;
        if (b.n != 0) bus.wdata_valid = 1'b0;
        chk("rsp_valid_reached", 32'(bus.rsp_valid), 1);
        if (b.gap == 0 && b.gmax == 0) chk("latency", lat, b.n == 0 ? 1 : 2 * b.n + 2);
        for (int h = 0; h <= b.hold; h++) begin
            chk("rsp_valid_held", 32'(bus.rsp_valid), 1);
            chk("rsp_err", 32'(bus.rsp_err), 32'(b.exp_err));
            chk("rsp_count", 32'(bus.rsp_count), b.exp_cnt);
            chk("no_mem_req_in_rsp", 32'(bus.mem_req), 0);
            bus.rsp_ready = (h == b.hold);
            tick();
        end
        bus.rsp_ready = 1'b0;
        bus.wdata_valid = 1'b0;
        chk("cmd_ready_after_rsp", 32'(bus.cmd_ready), 1);
        chk("rsp_valid_dropped", 32'(bus.rsp_valid), 0);
        chk("busy_after_rsp", 32'(bus.busy), 0);
        chk("words_consumed", wcons, b.n == 0 ? 0 : b.n + 1);
        chk("num_writes", writes.size(), b.n);
        for (int k = 0; k < b.n && k < writes.size(); k++) begin
            chk("write_addr", writes[k][63:32], base + 32'(4 * k));
            chk("write_data", writes[k][31:0], bdata[k]);
        end
        if (b.n > 0 && writes.size() == b.n) begin
            chk("first_addr", writes[0][63:32], b.exp_first);
            chk("last_addr", writes[b.n-1][63:32], b.exp_last);
        end
    endtask

    initial begin
        logic [31:0] c;
        errors = 0;
        checks = 0;
        wcons = 0;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : (c >> 1);
            crc_tab[i] = c;
        end
        tbl[0] = '{32'h1A11_2000, 1,   2, 1'b0, 1'b0, 1,   32'h1A11_2000, 32'h1A11_2000, 0,  0, 0};
        tbl[1] = '{32'h0010_0000, 255, 1, 1'b0, 1'b0, 255, 32'h0010_0000, 32'h0010_03F8, 0,  0, 0};
        tbl[2] = '{32'h0010_03FC, 3,   0, 1'b0, 1'b0, 3,   32'h0010_03FC, 32'h0010_0404, 0,  0, 0};
        tbl[3] = '{32'h2000_0010, 4,   0, 1'b1, 1'b1, 4,   32'h2000_0010, 32'h2000_001C, 0,  0, 1};
        tbl[4] = '{32'h1234_5678, 0,   0, 1'b0, 1'b1, 0,   32'h0,         32'h0,         0,  0, 0};
        tbl[5] = '{32'hFFFF_FFFC, 2,   0, 1'b0, 1'b0, 2,   32'hFFFF_FFFC, 32'h0000_0000, 20, 3, 3};
        tbl[6] = '{32'h4000_0003, 2,   0, 1'b0, 1'b0, 2,   32'h4000_0000, 32'h4000_0004, 30, 5, 3};
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_nwords = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;
        bus.mem_gnt = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk_reset("por");
        rst_n = 1'b1;
        tick();
        foreach (tbl[i]) run_burst(tbl[i]);
        for (int r = 0; r < 6; r++) begin
            v.addr = $urandom;
            v.n = $urandom_range(1, 24);
            v.pat = 0;
            v.bad = 1'($urandom_range(0, 1));
            v.exp_err = v.bad;
            v.exp_cnt = v.n;
            v.exp_first = v.addr & ~32'h3;
            v.exp_last = v.exp_first + 32'(4 * (v.n - 1));
            v.gap = 30;
            v.gmax = 5;
            v.hold = 3;
            run_burst(v);
        end
        writes.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 32'h3000_0000;
        bus.cmd_nwords = 8'd10;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 20 && !bus.wdata_ready; t++) tick();
            chk("rb_wdata_ready", 32'(bus.wdata_ready), 1);
            bus.wdata_valid = 1'b1;
            bus.wdata = 32'hA0 + 32'(k);
            tick();
            bus.wdata_valid = 1'b0;
            chk("rb_mem_req", 32'(bus.mem_req), 1);
            if (k < 2) begin
                bus.mem_gnt = 1'b1;
                tick();
                bus.mem_gnt = 1'b0;
            end
        end
        chk("rb_word3_addr", bus.mem_addr, 32'h3000_0008);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("mid");
        chk("rb_writes", writes.size(), 2);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("rb_no_rsp", 32'(bus.rsp_valid), 0);
        end
        run_burst(tbl[0]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
